seq_encoder8_3: RTL and testbench
=================================

Name: seq_encoder8_3

Overview:
- Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 decoder.
- Captures a multi-hot 8-bit request vector, then emits the 3-bit index of each set bit, one per transfer, over a valid/ready handshake.
- Sits downstream of decoder-driven select logic and turns one-hot/multi-hot lines back into indices for counters, muxes and adders.

Parameters:
- WIDTH, 8, request vector width; must equal 2**CODE_W.
- CODE_W, 3, index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- i_req  input  WIDTH  request vector; sampled only on an accepted load.
- i_load  input  1  load strobe; accepted only when o_busy=0.
- o_busy  output  1  high while a captured vector has untransferred bits.
- o_valid  output  1  o_code holds a valid index.
- o_code  output  CODE_W  index of the current set bit.
- i_ready  input  1  consumer accepts o_code this cycle.
- o_done  output  1  one-cycle pulse when a burst completes.
- o_count  output  CODE_W+1  number of codes transferred in the current or last burst.

Behaviour:
- Reset: all outputs 0 (o_busy, o_valid, o_code, o_done, o_count); pending vector cleared; state IDLE. Reset asserted mid-burst aborts the burst: no o_done, remaining bits discarded.
- State machine: IDLE and SCAN.
- IDLE, i_load=1, i_req!=0:
  - capture i_req into pending vector; clear o_count; go to SCAN.
  - next cycle: o_busy=1, o_valid=1, o_code = index of lowest set bit.
- IDLE, i_load=1, i_req==0:
  - clear o_count; stay in IDLE.
  - next cycle: o_done=1 for exactly one cycle; o_valid never asserts.
- SCAN:
  - o_valid=1 and o_code = lowest set bit of pending vector. o_code is derived only from registered state and changes only at clock edges.
  - Transfer occurs when o_valid=1 and i_ready=1: that bit is cleared from pending, o_count increments.
  - After a transfer with bits remaining: next index is presented the following cycle. Throughput is 1 code/cycle with i_ready held high.
  - After a transfer that clears the last bit: next cycle o_valid=0, o_busy=0, o_done=1 for one cycle, state IDLE.
  - i_ready=0: o_code and o_valid are held stable; no change to pending or o_count.
- Latency: first code is valid 1 cycle after load acceptance. A burst of N set bits with i_ready=1 throughout completes with o_done at load+N+1.
- i_load while o_busy=1 is ignored, including the final-transfer cycle. Earliest new load is the o_done cycle; a load accepted in that cycle gives o_valid the next cycle.
- i_req changes while busy have no effect.
- o_count saturation: not reachable (max WIDTH fits CODE_W+1 bits). o_count holds its value in IDLE until the next accepted load.
- i_ready while o_valid=0 is ignored.

Optional Feature:
- Macro: SEQ_ENCODER8_3_MSB_FIRST_EN.
- Defined: scan order is highest set bit first; o_code = index of the most significant pending bit.
- Undefined (default): lowest set bit first.
- Handshake, latency, o_count and o_done are identical in both builds.

Test Plan:
- Load 8'b1010_0100, i_ready=1 constantly -> o_code 2, 5, 7 on three consecutive valid cycles; o_done pulse on the following cycle; o_count=3; o_busy low after.
- Load 8'b0000_0011, i_ready=0 for 3 cycles then 1 -> o_code=0 held stable for 4 cycles, then o_code=1 for 1 cycle; o_done pulse; o_count=2.
- Load 8'h00 -> o_done pulse the next cycle; o_valid stays 0; o_count=0.
- Load 8'h81, then pulse i_load with 8'hFF during the burst -> only codes 0 and 7 are emitted; o_count=2. A new load of 8'hFF in the o_done cycle -> codes 0..7, o_count=8.
- Load 8'hF0, assert rst after the first transfer -> next cycle all outputs 0, no o_done. A subsequent load of 8'h01 -> code 0 only.
- Build with SEQ_ENCODER8_3_MSB_FIRST_EN, load 8'b1010_0100 -> o_code 7, 5, 2; o_count=3.

Source files
------------

// File: rtl/seq_encoder8_3.sv
// seq_encoder8_3 -- sequential 8-to-3 encoder.
//
// Captures a multi-hot request vector on an accepted load. It then emits the
// index of each set bit, one per valid/ready transfer. When the last index has
// been taken, o_done pulses for one cycle and the block returns to idle.
//
// Build option:
//   SEQ_ENCODER8_3_MSB_FIRST_EN  defined   -> highest pending bit is emitted first
//                                undefined -> lowest pending bit is emitted first
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   i_req    request vector, sampled only on an accepted load
//   i_load   load strobe, accepted only while o_busy=0
//   o_busy   a captured vector still has untransferred bits
//   o_valid  o_code holds a valid index
//   o_code   index of the current pending bit
//   i_ready  consumer takes o_code this cycle
//   o_done   one-cycle pulse when a burst completes
//   o_count  codes transferred in the current or last burst

module seq_encoder8_3 #(
   parameter int unsigned WIDTH  = 8,  // must equal 2**CODE_W
   parameter int unsigned CODE_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  i_req,
   input  logic              i_load,
   output logic              o_busy,
   output logic              o_valid,
   output logic [CODE_W-1:0] o_code,
   input  logic              i_ready,
   output logic              o_done,
   output logic [CODE_W:0]   o_count
);

   typedef enum logic [0:0] {StIdle, StScan} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  pending_q, pending_d;
   logic [CODE_W:0]   count_q, count_d;
   logic              done_q, done_d;
   logic [CODE_W-1:0] code;
   logic [WIDTH-1:0]  pending_clr;

   // Priority pick over registered state only, so o_code moves only at edges.
   // The scan direction is chosen so that the last hit written is the winner.
   always_comb begin
      code = '0;
`ifdef SEQ_ENCODER8_3_MSB_FIRST_EN
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (pending_q[i]) code = CODE_W'(i);
      end
`else
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (pending_q[i]) code = CODE_W'(i);
      end
`endif
   end

   // Pending vector with the current bit removed (the post-transfer value).
   assign pending_clr = pending_q & ~(WIDTH'(1) << code);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_load) begin
               count_d = '0;
               if (i_req != '0) begin
                  pending_d = i_req;
                  state_d   = StScan;
               end else begin
                  // An empty load completes at once, as a zero-length burst.
                  done_d = 1'b1;
               end
            end
         end
         StScan: begin
            if (i_ready) begin
               pending_d = pending_clr;
               count_d   = count_q + {{CODE_W{1'b0}}, 1'b1};
               if (pending_clr == '0) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         pending_q <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         done_q    <= done_d;
      end
   end

   assign o_busy  = (state_q == StScan);
   assign o_valid = (state_q == StScan);
   assign o_code  = code;
   assign o_done  = done_q;
   assign o_count = count_q;

endmodule

// File: tb/tb_seq_encoder8_3.sv
// Self-checking bench for seq_encoder8_3. The reference model keeps the list of
// indices still owed as a queue. The list is built from the request vector in
// emission order, and the model pops one index per accepted transfer.
module tb_seq_encoder8_3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] i_req;
   logic       i_load;
   logic       o_busy;
   logic       o_valid;
   logic [2:0] o_code;
   logic       i_ready;
   logic       o_done;
   logic [3:0] o_count;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int       m_q[$];
   int       m_count;
   bit       m_done;

   always #5 clk = ~clk;

   seq_encoder8_3 #(.WIDTH(8), .CODE_W(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_load  (i_load),
      .o_busy  (o_busy),
      .o_valid (o_valid),
      .o_code  (o_code),
      .i_ready (i_ready),
      .o_done  (o_done),
      .o_count (o_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Indices of the set bits, in the order the encoder must emit them.
   function automatic void build_codes(input logic [7:0] v);
      m_q.delete();
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
`ifdef SEQ_ENCODER8_3_MSB_FIRST_EN
            m_q.push_front(i);
`else
            m_q.push_back(i);
`endif
         end
      end
   endfunction

   task automatic check_outputs();
      bit busy;
      busy = (m_q.size() > 0);
      check("busy",  {31'd0, o_busy},  {31'd0, busy});
      check("valid", {31'd0, o_valid}, {31'd0, busy});
      check("done",  {31'd0, o_done},  {31'd0, m_done});
      check("count", {28'd0, o_count}, m_count);
      if (busy) check("code", {29'd0, o_code}, m_q[0]);
   endtask

   // Check the current outputs, apply one cycle of inputs, advance the model,
   // and land on the following negedge.
   task automatic step(input logic r, input logic ld, input logic [7:0] rq, input logic rdy);
      check_outputs();
      rst = r; i_load = ld; i_req = rq; i_ready = rdy;
      if (r) begin
         m_q.delete(); m_count = 0; m_done = 0;
      end else if (m_q.size() > 0) begin
         m_done = 0;
         if (rdy) begin
            void'(m_q.pop_front());
            m_count++;
            if (m_q.size() == 0) m_done = 1;
         end
      end else begin
         m_done = 0;
         if (ld) begin
            m_count = 0;
            build_codes(rq);
            if (m_q.size() == 0) m_done = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      logic [7:0] rq;
      rst = 1'b1; i_load = 1'b0; i_req = '0; i_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_q.delete(); m_count = 0; m_done = 0;
      check("rst_code", {29'd0, o_code}, 32'd0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Three-code burst with ready held high.
      step(1'b0, 1'b1, 8'b1010_0100, 1'b1);
      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
      check("tp1_count", {28'd0, o_count}, 32'd3);
      idle(2);

      // Consumer stalls for three cycles, then drains.
      step(1'b0, 1'b1, 8'b0000_0011, 1'b0);
      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
      repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);
      check("tp2_count", {28'd0, o_count}, 32'd2);
      idle(1);

      // Empty load completes immediately.
      step(1'b0, 1'b1, 8'h00, 1'b1);
      check("tp3_done", {31'd0, o_done}, 32'd1);
      idle(2);

      // Load during a burst is ignored; a reload in the o_done cycle is taken.
      step(1'b0, 1'b1, 8'h81, 1'b1);
      step(1'b0, 1'b1, 8'hFF, 1'b1);
      step(1'b0, 1'b1, 8'hFF, 1'b1);   // final-transfer cycle: load ignored
      check("tp4_count", {28'd0, o_count}, 32'd2);
      step(1'b0, 1'b1, 8'hFF, 1'b1);   // o_done cycle: load accepted
      repeat (8) step(1'b0, 1'b0, 8'h00, 1'b1);
      check("tp4_count8", {28'd0, o_count}, 32'd8);
      idle(1);

      // Reset after the first transfer aborts the burst.
      step(1'b0, 1'b1, 8'hF0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      check("tp5_done", {31'd0, o_done}, 32'd0);
      check("tp5_code", {29'd0, o_code}, 32'd0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b1, 8'h01, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("tp5_count", {28'd0, o_count}, 32'd1);
      idle(1);

      // Randomised traffic: stalls, stray loads, occasional resets.
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 3))
            0: rq = 8'h00;
            1: rq = 8'h01 << $urandom_range(0, 7);
            default: rq = 8'($urandom);
         endcase
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35), rq,
              ($urandom_range(0, 99) < 65));
      end
      step(1'b0, 1'b0, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
